// File: rtl/reg_bank_pkg.sv
// Shared op-code constants, FSM state encoding and default data width
// for the four-entry register bank.
package reg_bank_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_MOVE = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWAP2 = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bank_if.sv
// Operation request bus and register readout of the register bank.
// master = requester, slave = reg_bank.
interface reg_bank_if import reg_bank_pkg::*; #(parameter int WIDTH = WIDTH_DEF) ();

  logic [2:0]       Op;
  logic [1:0]       Dst;
  logic [1:0]       Src;
  logic [WIDTH-1:0] Data_In;
  logic             Op_Valid;
  logic             Op_Ready;
  logic [WIDTH-1:0] THE_REG0;
  logic [WIDTH-1:0] THE_REG1;
  logic [WIDTH-1:0] THE_REG2;
  logic [WIDTH-1:0] THE_REG3;
  logic [3:0]       Zero;
  logic             Wrap;

  modport master (
    output Op, Dst, Src, Data_In, Op_Valid,
    input  Op_Ready, THE_REG0, THE_REG1, THE_REG2, THE_REG3, Zero, Wrap
  );

  modport slave (
    input  Op, Dst, Src, Data_In, Op_Valid,
    output Op_Ready, THE_REG0, THE_REG1, THE_REG2, THE_REG3, Zero, Wrap
  );

endinterface

// File: rtl/reg_bank_alu.sv
// Combinational next-value logic for the destination register.
// For SWAP it supplies the first half (R[Dst] <= R[Src]); the write-back
// of the saved value is handled by the FSM in reg_bank.
module reg_bank_alu import reg_bank_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] r_dst,
  input  logic [WIDTH-1:0] r_src,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] next_val,
  output logic             wr_en,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // decode op into destination write value, write strobe and wrap flag
  always_comb begin
    next_val = r_dst;
    wr_en    = 1'b0;
    wrap     = 1'b0;
    case (op)
      OP_LOAD: begin
        next_val = data_in;
        wr_en    = 1'b1;
      end
      OP_MOVE, OP_SWAP: begin
        next_val = r_src;
        wr_en    = 1'b1;
      end
      OP_INC: begin
        next_val = r_dst + ONE;
        wr_en    = 1'b1;
        wrap     = &r_dst;
      end
      OP_DEC: begin
        next_val = r_dst - ONE;
        wr_en    = 1'b1;
        wrap     = ~|r_dst;
      end
      OP_CLR: begin
        next_val = '0;
        wr_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Four-entry register bank with immediate load, move, inc/dec with wrap
// flag, clear, and a two-cycle swap.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | ready; accepts one op per cycle when Op_Valid
//   ST_SWAP2 | second half of SWAP: R[latched Src] <= TMP; inputs ignored
module reg_bank import reg_bank_pkg::*; #(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic       Clock,
  input logic       Reset,
  reg_bank_if.slave bus
);

  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] tmp;
  logic [1:0]       swap_idx;
  state_e           state;
  logic             ready_q;
  logic             wrap_q;

  logic [WIDTH-1:0] alu_next;
  logic             alu_wr;
  logic             alu_wrap;
  logic             accept;

  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .op       (bus.Op),
    .r_dst    (regs[bus.Dst]),
    .r_src    (regs[bus.Src]),
    .data_in  (bus.Data_In),
    .next_val (alu_next),
    .wr_en    (alu_wr),
    .wrap     (alu_wrap)
  );

  assign accept = bus.Op_Valid && ready_q;

  // register storage, swap scratch and FSM; reset overrides everything,
  // including an unfinished swap
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= RESET_VALUE;
      tmp      <= '0;
      swap_idx <= '0;
      state    <= ST_IDLE;
      ready_q  <= 1'b1;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (alu_wr) regs[bus.Dst] <= alu_next;
            wrap_q <= alu_wrap;
            if (bus.Op == OP_SWAP) begin
              tmp      <= regs[bus.Dst];
              swap_idx <= bus.Src;
              state    <= ST_SWAP2;
              ready_q  <= 1'b0;
            end
          end
        end
        ST_SWAP2: begin
          regs[swap_idx] <= tmp;
          state          <= ST_IDLE;
          ready_q        <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Op_Ready = ready_q;
  assign bus.Wrap     = wrap_q;
  assign bus.THE_REG0 = regs[0];
  assign bus.THE_REG1 = regs[1];
  assign bus.THE_REG2 = regs[2];
  assign bus.THE_REG3 = regs[3];
  assign bus.Zero     = {regs[3] == '0, regs[2] == '0, regs[1] == '0, regs[0] == '0};

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, hand-written
// swap/reset sequences, then randomized ops against a behavioural model.
module tb_reg_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_if #(.WIDTH(16)) bus ();

  reg_bank #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;

  // behavioural model: register array plus a pending swap write-back
  logic [15:0] m_r [4];
  logic        m_busy = 1'b0;
  logic [1:0]  m_pidx = 2'd0;
  logic [15:0] m_pval = 16'h0;
  logic        m_wrap = 1'b0;

  typedef struct {
    logic        r;
    logic        v;
    logic [2:0]  op;
    logic [1:0]  d;
    logic [1:0]  s;
    logic [15:0] data;
    logic [15:0] e0, e1, e2, e3;
    logic        ew;
    logic        er;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] op,
                       input logic [1:0] d, input logic [1:0] s, input logic [15:0] data);
    rst          = r;
    bus.Op_Valid = v;
    bus.Op       = op;
    bus.Dst      = d;
    bus.Src      = s;
    bus.Data_In  = data;
  endtask

  task automatic model_step();
    logic [1:0] d;
    logic [1:0] s;
    d = bus.Dst;
    s = bus.Src;
    m_wrap = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0000;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_r[m_pidx] = m_pval;
      m_busy = 1'b0;
    end else if (bus.Op_Valid) begin
      case (bus.Op)
        3'd1: m_r[d] = bus.Data_In;
        3'd2: m_r[d] = m_r[s];
        3'd3: begin
          m_wrap = (m_r[d] == 16'hFFFF);
          m_r[d] = 16'((int'(m_r[d]) + 1) % 65536);
        end
        3'd4: begin
          m_wrap = (m_r[d] == 16'h0000);
          m_r[d] = 16'((int'(m_r[d]) + 65535) % 65536);
        end
        3'd5: m_r[d] = 16'h0000;
        3'd6: begin
          m_pval = m_r[d];
          m_pidx = s;
          m_r[d] = m_r[s];
          m_busy = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  // one clock: update the model at the edge, then compare 1 time unit later
  task automatic cycle();
    logic [3:0] ez;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 4; i++) ez[i] = (m_r[i] == 16'h0000);
    chk("reg0", 32'(bus.THE_REG0), 32'(m_r[0]));
    chk("reg1", 32'(bus.THE_REG1), 32'(m_r[1]));
    chk("reg2", 32'(bus.THE_REG2), 32'(m_r[2]));
    chk("reg3", 32'(bus.THE_REG3), 32'(m_r[3]));
    chk("zero", 32'(bus.Zero), 32'(ez));
    chk("wrap", 32'(bus.Wrap), 32'(m_wrap));
    chk("ready", 32'(bus.Op_Ready), 32'(!m_busy));
  endtask

  initial begin
    logic [3:0] ez;

    //          r     v     op    d     s     data      e0        e1        e2        e3       ew    er
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 2'd2, 2'd0, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 3'd1, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 3'd4, 2'd0, 2'd0, 16'h0000, 16'hFFFF, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3'd1, 2'd1, 2'd0, 16'h0005, 16'hFFFF, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 3'd1, 2'd1, 2'd0, 16'h00FF, 16'hFFFF, 16'h00FF, 16'h1234, 16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 3'd2, 2'd2, 2'd1, 16'h0000, 16'hFFFF, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 3'd5, 2'd1, 2'd0, 16'h7777, 16'hFFFF, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 3'd7, 2'd2, 2'd3, 16'h7777, 16'hFFFF, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 3'd2, 2'd3, 2'd3, 16'h0000, 16'hFFFF, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 3'd3, 2'd3, 2'd0, 16'h0000, 16'hFFFF, 16'h0000, 16'h00FF, 16'h0001, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 3'd4, 2'd1, 2'd0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0001, 1'b1, 1'b1};

    drive(1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 16'h0);

    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].r, vecs[k].v, vecs[k].op, vecs[k].d, vecs[k].s, vecs[k].data);
      cycle();
      ez = {vecs[k].e3 == 16'h0, vecs[k].e2 == 16'h0, vecs[k].e1 == 16'h0, vecs[k].e0 == 16'h0};
      chk($sformatf("vec%0d_r0", k), 32'(bus.THE_REG0), 32'(vecs[k].e0));
      chk($sformatf("vec%0d_r1", k), 32'(bus.THE_REG1), 32'(vecs[k].e1));
      chk($sformatf("vec%0d_r2", k), 32'(bus.THE_REG2), 32'(vecs[k].e2));
      chk($sformatf("vec%0d_r3", k), 32'(bus.THE_REG3), 32'(vecs[k].e3));
      chk($sformatf("vec%0d_zero", k), 32'(bus.Zero), 32'(ez));
      chk($sformatf("vec%0d_wrap", k), 32'(bus.Wrap), 32'(vecs[k].ew));
      chk($sformatf("vec%0d_ready", k), 32'(bus.Op_Ready), 32'(vecs[k].er));
    end

    // swap with a competing LOAD held during the busy cycle
    drive(1'b0, 1'b1, 3'd1, 2'd0, 2'd0, 16'h1111); cycle();
    drive(1'b0, 1'b1, 3'd1, 2'd1, 2'd0, 16'hAAAA); cycle();
    drive(1'b0, 1'b1, 3'd1, 2'd3, 2'd0, 16'h5555); cycle();
    drive(1'b0, 1'b1, 3'd6, 2'd1, 2'd3, 16'h0000); cycle();
    chk("swap_busy_ready", 32'(bus.Op_Ready), 32'd0);
    chk("swap_half_r1", 32'(bus.THE_REG1), 32'h5555);
    drive(1'b0, 1'b1, 3'd1, 2'd0, 2'd0, 16'h0BAD); cycle();
    chk("swap_r1", 32'(bus.THE_REG1), 32'h5555);
    chk("swap_r3", 32'(bus.THE_REG3), 32'hAAAA);
    chk("swap_r0_kept", 32'(bus.THE_REG0), 32'h1111);
    chk("swap_ready_back", 32'(bus.Op_Ready), 32'd1);

    // swap onto itself: two cycles, value unchanged
    drive(1'b0, 1'b1, 3'd6, 2'd1, 2'd1, 16'h0000); cycle();
    chk("selfswap_busy", 32'(bus.Op_Ready), 32'd0);
    chk("selfswap_mid", 32'(bus.THE_REG1), 32'h5555);
    drive(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 16'h0000); cycle();
    chk("selfswap_end", 32'(bus.THE_REG1), 32'h5555);
    chk("selfswap_ready", 32'(bus.Op_Ready), 32'd1);

    // reset during the second half of a swap
    drive(1'b0, 1'b1, 3'd6, 2'd1, 2'd3, 16'h0000); cycle();
    drive(1'b1, 1'b1, 3'd1, 2'd2, 2'd0, 16'hBEEF); cycle();
    chk("rstswap_r1", 32'(bus.THE_REG1), 32'h0000);
    chk("rstswap_r3", 32'(bus.THE_REG3), 32'h0000);
    chk("rstswap_ready", 32'(bus.Op_Ready), 32'd1);
    drive(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 16'h0000); cycle();
    chk("rstswap_r3_after", 32'(bus.THE_REG3), 32'h0000);
    chk("rstswap_ready_after", 32'(bus.Op_Ready), 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] dv;
      case ($urandom_range(0, 3))
        0: dv = 16'h0000;
        1: dv = 16'hFFFF;
        default: dv = 16'($urandom);
      endcase
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), dv);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
